branch_resolve_unit: RTL and testbench

//   Pipelined branch resolution unit for the RV32 core; the next generation of
//   the combinational BrEq/BrLT comparator.
//   - Accepts one branch per cycle over a valid/ready handshake.
//   - Decodes funct3 into all six RV32I conditions and produces taken/target.
//   - Flags mispredicts against the fetch-stage prediction.
//   - Sits between decode/execute and the PC-redirect logic.
//

---
 rtl/branch_resolve_unit_if.sv | 33 +++
 rtl/branch_resolve_unit.sv | 185 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Branch request/result bus between execute and the branch resolve unit.
// master: issuing side (drives requests, accepts results).
// slave : the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            br_eq;
  logic            br_lt;
  logic            taken;
  logic            illegal;
  logic [XLEN-1:0] redirect_pc;
  logic            mispredict;

  modport master (
    output in_valid, rs1, rs2, funct3, pc, imm, pred_taken, out_ready,
    input  in_ready, out_valid, br_eq, br_lt, taken, illegal, redirect_pc, mispredict
  );

  modport slave (
    input  in_valid, rs1, rs2, funct3, pc, imm, pred_taken, out_ready,
    output in_ready, out_valid, br_eq, br_lt, taken, illegal, redirect_pc, mispredict
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution unit (RV32I BEQ/BNE/BLT/BGE/BLTU/BGEU).
// STAGES=1: compare and decide in one registered stage.
// STAGES=2: stage 1 registers eq/lts/ltu and pc+imm / pc+4, stage 2 decides.
// Optional feature macro: BRU_PERF_EN adds perf_branches / perf_mispredicts
// counters and ports.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
`ifdef BRU_PERF_EN
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispredicts,
`endif
  branch_resolve_unit_if.slave bus
);
  localparam int NS = (STAGES == 1) ? 1 : 2;

  typedef struct packed {
    logic            br_eq;
    logic            br_lt;
    logic            taken;
    logic            illegal;
    logic            mis_raw;
    logic [XLEN-1:0] redirect_pc;
  } res_t;

  typedef struct packed {
    logic            eq;
    logic            lts;
    logic            ltu;
    logic [2:0]      f3;
    logic            pred;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq;
  } s1_t;

  // Final decision from the raw comparison flags; mis_raw is gated by valid at the output.
  function automatic res_t decide(input logic eq, input logic lts, input logic ltu,
                                  input logic [2:0] f3, input logic pred,
                                  input logic [XLEN-1:0] target,
                                  input logic [XLEN-1:0] seq);
    res_t r;
    r         = '0;
    r.br_eq   = eq;
    r.br_lt   = f3[1] ? ltu : lts;
    r.illegal = (f3[2:1] == 2'b01);
    case (f3)
      3'b000:  r.taken = eq;
      3'b001:  r.taken = ~eq;
      3'b100:  r.taken = lts;
      3'b101:  r.taken = ~lts;
      3'b110:  r.taken = ltu;
      3'b111:  r.taken = ~ltu;
      default: r.taken = 1'b0;
    endcase
    r.mis_raw     = ~r.illegal & (r.taken != pred);
    r.redirect_pc = r.taken ? target : seq;
    return r;
  endfunction

  // Operand compares and both candidate PCs for the incoming request.
  logic            in_eq, in_lts, in_ltu;
  logic [XLEN-1:0] in_target, in_seq;
  always_comb begin
    in_eq     = (bus.rs1 == bus.rs2);
    in_ltu    = (bus.rs1 < bus.rs2);
    in_lts    = ($signed(bus.rs1) < $signed(bus.rs2));
    in_target = bus.pc + bus.imm;
    in_seq    = bus.pc + XLEN'(4);
  end

  // Stage valids; vld_pipe[0] is the incoming request.
  logic [NS:1]   vld_pipe_q, vld_pipe_d;
  logic [NS:0]   vld_pipe;
  logic [NS+1:1] adv;
  logic [NS:1]   ld;

  // Each stage moves when empty or when the next one moves; flush kills everything.
  always_comb begin
    vld_pipe   = {vld_pipe_q, bus.in_valid};
    adv        = '0;
    ld         = '0;
    vld_pipe_d = '0;
    adv[NS+1]  = bus.out_ready;
    for (int k = NS; k >= 1; k--) begin
      adv[k] = ~vld_pipe[k] | adv[k+1];
    end
    for (int k = 1; k <= NS; k++) begin
      ld[k]         = adv[k] & vld_pipe[k-1] & ~flush;
      vld_pipe_d[k] = flush ? 1'b0 : (adv[k] ? vld_pipe[k-1] : vld_pipe[k]);
    end
  end

  // Stage valid register.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  res_t res_q, res_d;

  generate
    if (NS == 1) begin : g_one
      // Decide straight from the input and capture on acceptance.
      always_comb begin
        res_d = res_q;
        if (ld[1]) res_d = decide(in_eq, in_lts, in_ltu, bus.funct3, bus.pred_taken,
                                  in_target, in_seq);
      end
    end else begin : g_two
      s1_t s1_q, s1_d;

      // Stage 1 captures compare flags and both candidate PCs.
      always_comb begin
        s1_d = s1_q;
        if (ld[1]) begin
          s1_d.eq     = in_eq;
          s1_d.lts    = in_lts;
          s1_d.ltu    = in_ltu;
          s1_d.f3     = bus.funct3;
          s1_d.pred   = bus.pred_taken;
          s1_d.target = in_target;
          s1_d.seq    = in_seq;
        end
      end

      // Stage 1 payload register.
      always_ff @(posedge clk) begin
        if (rst) s1_q <= '0;
        else     s1_q <= s1_d;
      end

      // Stage 2 decides from the registered flags.
      always_comb begin
        res_d = res_q;
        if (ld[2]) res_d = decide(s1_q.eq, s1_q.lts, s1_q.ltu, s1_q.f3, s1_q.pred,
                                  s1_q.target, s1_q.seq);
      end
    end
  endgenerate

  // Output payload register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign bus.in_ready    = adv[1];
  assign bus.out_valid   = vld_pipe_q[NS];
  assign bus.br_eq       = res_q.br_eq;
  assign bus.br_lt       = res_q.br_lt;
  assign bus.taken       = res_q.taken;
  assign bus.illegal     = res_q.illegal;
  assign bus.redirect_pc = res_q.redirect_pc;
  assign bus.mispredict  = vld_pipe_q[NS] & res_q.mis_raw;

`ifdef BRU_PERF_EN
  logic [31:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;
  logic        out_fire;

  // Count at the output transfer; flush never retracts a completed transfer.
  always_comb begin
    out_fire   = vld_pipe_q[NS] & bus.out_ready;
    perf_br_d  = perf_br_q  + {31'd0, out_fire & ~res_q.illegal};
    perf_mis_d = perf_mis_q + {31'd0, out_fire & bus.mispredict};
  end

  // Perf counters clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one instance per depth (STAGES=1
// and STAGES=2) driven side by side; expected values are hand computed.
module tb_branch_resolve_unit;
  typedef struct packed {
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  req_t req [2];

  logic        o_in_ready [2];
  logic        o_out_valid[2];
  logic        o_eq [2];
  logic        o_lt [2];
  logic        o_tk [2];
  logic        o_ill[2];
  logic        o_mis[2];
  logic [31:0] o_rpc[2];
`ifdef BRU_PERF_EN
  logic [31:0] o_pb[2];
  logic [31:0] o_pm[2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      branch_resolve_unit_if #(.XLEN(32)) bif ();
      assign bif.in_valid   = req[g].valid;
      assign bif.rs1        = req[g].rs1;
      assign bif.rs2        = req[g].rs2;
      assign bif.funct3     = req[g].f3;
      assign bif.pc         = req[g].pc;
      assign bif.imm        = req[g].imm;
      assign bif.pred_taken = req[g].pred;
      assign bif.out_ready  = out_ready;
      assign o_in_ready[g]  = bif.in_ready;
      assign o_out_valid[g] = bif.out_valid;
      assign o_eq[g]        = bif.br_eq;
      assign o_lt[g]        = bif.br_lt;
      assign o_tk[g]        = bif.taken;
      assign o_ill[g]       = bif.illegal;
      assign o_mis[g]       = bif.mispredict;
      assign o_rpc[g]       = bif.redirect_pc;

      branch_resolve_unit #(.XLEN(32), .STAGES(g + 1)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
`ifdef BRU_PERF_EN
        .perf_branches    (o_pb[g]),
        .perf_mispredicts (o_pm[g]),
`endif
        .bus              (bif)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic put(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f, input logic [31:0] p, input logic [31:0] i,
                     input logic pr);
    req[d] = '{valid: v, rs1: a, rs2: b, f3: f, pc: p, imm: i, pred: pr};
  endtask

  task automatic put_both(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic [31:0] p, input logic [31:0] i,
                          input logic pr);
    put(0, v, a, b, f, p, i, pr);
    put(1, v, a, b, f, p, i, pr);
  endtask

  task automatic chk_res(input string tag, input int d, input logic eq, input logic lt,
                         input logic tk, input logic ill, input logic [31:0] rpc,
                         input logic mis);
    check($sformatf("%s.d%0d.valid", tag, d), 32'(o_out_valid[d]), 32'd1);
    check($sformatf("%s.d%0d.br_eq", tag, d), 32'(o_eq[d]),  32'(eq));
    check($sformatf("%s.d%0d.br_lt", tag, d), 32'(o_lt[d]),  32'(lt));
    check($sformatf("%s.d%0d.taken", tag, d), 32'(o_tk[d]),  32'(tk));
    check($sformatf("%s.d%0d.illegal", tag, d), 32'(o_ill[d]), 32'(ill));
    check($sformatf("%s.d%0d.rpc", tag, d), o_rpc[d], rpc);
    check($sformatf("%s.d%0d.mispredict", tag, d), 32'(o_mis[d]), 32'(mis));
  endtask

  // One request into empty pipes with out_ready=1: result after 1 / 2 cycles.
  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] p, input logic [31:0] i,
                         input logic pr, input logic eq, input logic lt, input logic tk,
                         input logic ill, input logic [31:0] rpc, input logic mis);
    put_both(1'b1, a, b, f, p, i, pr);
    @(negedge clk);
    check({tag, ".d0.in_ready"}, 32'(o_in_ready[0]), 32'd1);
    check({tag, ".d1.in_ready"}, 32'(o_in_ready[1]), 32'd1);
    @(posedge clk); #1;
    put_both(1'b0, a, b, f, p, i, pr);
    @(negedge clk);
    chk_res(tag, 0, eq, lt, tk, ill, rpc, mis);
    check({tag, ".d1.early_valid"}, 32'(o_out_valid[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_res(tag, 1, eq, lt, tk, ill, rpc, mis);
    check({tag, ".d0.drained"}, 32'(o_out_valid[0]), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic put_bp(input int d, input int k);
    put(d, k < 4, 32'(k), 32'(k), 3'b000, 32'h1000 + 32'(k * 16), 32'h100, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx[2];
    int   got[2];
    int   first[2];
    int   last[2];
    logic acc[2];

    put_both(1'b0, '0, '0, 3'b000, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst.d%0d.valid", d), 32'(o_out_valid[d]), 32'd0);
      check($sformatf("rst.d%0d.in_ready", d), 32'(o_in_ready[d]), 32'd1);
      check($sformatf("rst.d%0d.taken", d), 32'(o_tk[d]), 32'd0);
      check($sformatf("rst.d%0d.br_eq", d), 32'(o_eq[d]), 32'd0);
      check($sformatf("rst.d%0d.rpc", d), o_rpc[d], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    //      tag      rs1           rs2           f3      pc            imm           pr   eq   lt   tk   ill  rpc           mis
    run_vec("blt",   32'hFFFFFFFF, 32'h1,        3'b100, 32'h200,      32'h10,       1, 0, 1, 1, 0, 32'h210,      0);
    run_vec("bltu",  32'hFFFFFFFF, 32'h1,        3'b110, 32'h200,      32'h10,       1, 0, 0, 0, 0, 32'h204,      1);
    run_vec("beq",   32'h1234,     32'h1234,     3'b000, 32'h100,      32'hFFFFFFF0, 0, 1, 0, 1, 0, 32'hF0,       1);
    run_vec("ill010",32'h7,        32'h5,        3'b010, 32'h300,      32'h40,       1, 0, 0, 0, 1, 32'h304,      0);
    run_vec("wrap",  32'h1,        32'h2,        3'b001, 32'hFFFFFFFC, 32'h8,        1, 0, 1, 1, 0, 32'h4,        0);
    run_vec("bge",   32'h80000000, 32'h0,        3'b101, 32'h400,      32'h20,       0, 0, 1, 0, 0, 32'h404,      0);
    run_vec("bgeu",  32'h80000000, 32'h0,        3'b111, 32'h400,      32'h20,       0, 0, 0, 1, 0, 32'h420,      1);
    run_vec("bne_eq",32'h9,        32'h9,        3'b001, 32'h500,      32'h8,        1, 1, 0, 0, 0, 32'h504,      1);
    run_vec("ill011",32'h3,        32'h3,        3'b011, 32'h10,       32'h40,       0, 1, 0, 0, 1, 32'h14,       0);

`ifdef BRU_PERF_EN
    for (int d = 0; d < 2; d++) begin
      check($sformatf("perf.d%0d.branches", d), o_pb[d], 32'd7);
      check($sformatf("perf.d%0d.mispredicts", d), o_pm[d], 32'd4);
    end
`endif

    // Backpressure: four back-to-back requests against a stalled consumer.
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; got[d] = 0; first[d] = -1; last[d] = -1;
      put_bp(d, 0);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        acc[d] = req[d].valid & o_in_ready[d];
        if (c == 3 || c == 5) begin
          check($sformatf("bp.c%0d.d%0d.accepted", c, d), 32'(idx[d]), 32'(d + 1));
          check($sformatf("bp.c%0d.d%0d.in_ready", c, d), 32'(o_in_ready[d]), 32'd0);
          check($sformatf("bp.c%0d.d%0d.valid", c, d), 32'(o_out_valid[d]), 32'd1);
          check($sformatf("bp.c%0d.d%0d.rpc", c, d), o_rpc[d], 32'h1100);
        end
        if (o_out_valid[d] && out_ready) begin
          check($sformatf("bp.d%0d.order%0d", d, got[d]), o_rpc[d], 32'h1100 + 32'(got[d] * 16));
          if (got[d] == 0) first[d] = c;
          last[d] = c;
          got[d]++;
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) idx[d]++;
        put_bp(d, idx[d]);
      end
      if (c == 5) out_ready = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("bp.d%0d.count", d), 32'(got[d]), 32'd4);
      check($sformatf("bp.d%0d.span", d), 32'(last[d] - first[d]), 32'd3);
    end

    // Flush with full pipes and a new request offered in the flush cycle.
    out_ready = 1'b0;
    put_both(1'b1, 32'h0, 32'h0, 3'b000, 32'h2000, 32'h40, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    put_both(1'b1, 32'h0, 32'h0, 3'b000, 32'h3000, 32'h40, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    put_both(1'b0, 32'h0, 32'h0, 3'b000, 32'h3000, 32'h40, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("flfull.c%0d.d%0d.valid", c, d), 32'(o_out_valid[d]), 32'd0);
        check($sformatf("flfull.c%0d.d%0d.in_ready", c, d), 32'(o_in_ready[d]), 32'd1);
      end
      @(posedge clk); #1;
    end

    // Flush into empty pipes drops the request even though in_ready=1.
    put_both(1'b1, 32'h0, 32'h0, 3'b000, 32'h4000, 32'h40, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("flempty.d%0d.in_ready", d), 32'(o_in_ready[d]), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    put_both(1'b0, 32'h0, 32'h0, 3'b000, 32'h4000, 32'h40, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        check($sformatf("flempty.c%0d.d%0d.valid", c, d), 32'(o_out_valid[d]), 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a stall, together with flush.
    out_ready = 1'b0;
    put_both(1'b1, 32'h5, 32'h5, 3'b000, 32'h6000, 32'h40, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rststall.d%0d.in_ready", d), 32'(o_in_ready[d]), 32'd0);
      check($sformatf("rststall.d%0d.valid", d), 32'(o_out_valid[d]), 32'd1);
`ifdef BRU_PERF_EN
      check($sformatf("rststall.d%0d.perf_br", d), o_pb[d], 32'd11);
      check($sformatf("rststall.d%0d.perf_mis", d), o_pm[d], 32'd4);
`endif
    end
    @(posedge clk); #1;
    rst = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush = 1'b0;
    put_both(1'b0, 32'h5, 32'h5, 3'b000, 32'h6000, 32'h40, 1'b0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("postrst.d%0d.valid", d), 32'(o_out_valid[d]), 32'd0);
      check($sformatf("postrst.d%0d.in_ready", d), 32'(o_in_ready[d]), 32'd1);
      check($sformatf("postrst.d%0d.rpc", d), o_rpc[d], 32'd0);
      check($sformatf("postrst.d%0d.taken", d), 32'(o_tk[d]), 32'd0);
`ifdef BRU_PERF_EN
      check($sformatf("postrst.d%0d.perf_br", d), o_pb[d], 32'd0);
      check($sformatf("postrst.d%0d.perf_mis", d), o_pm[d], 32'd0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
